// File: rtl/acc_bank_tx_if.sv
// Host-side bundle for acc_bank_tx: operand/command strobes,
// transmitter handshake and status flags.
interface acc_bank_tx_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  logic          in_valid;
  logic [7:0]    in_data;
  logic [CW-1:0] ch_sel;
  logic          add;
  logic          clear;
  logic          dump;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
  logic [NCH-1:0] ovf;

  modport master (
    output in_valid, in_data, ch_sel,
    output add, clear, dump, tx_busy,
    input  tx_start, tx_data, busy, ovf
  );

  modport slave (
    input  in_valid, in_data, ch_sel,
    input  add, clear, dump, tx_busy,
    output tx_start, tx_data, busy, ovf
  );
endinterface

// File: rtl/acc_bank_tx.sv
// Multi-channel wide accumulator bank with a byte-serial,
// MSB-first dump engine driving an external transmitter.
module acc_bank_tx #(
  parameter int WIDTH = 128,
  parameter int NCH   = 4
) (
  input logic          clk,
  input logic          nRst,
  acc_bank_tx_if.slave bus
);
  localparam int NB   = WIDTH / 8;
  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_HI, WAIT_LO
  } state_t;

  logic [WIDTH-1:0] acc [NCH];
  logic [WIDTH-1:0] operand;
  logic [NCH-1:0]   ovf_q;
  logic [WIDTH:0]   sum;
  logic             ch_ok;

  state_t           state;
  logic [WIDTH-1:0] snap;
  logic [CNTW-1:0]  cnt;
  logic [CW-1:0]    dch;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;

  // Out-of-range selects only exist when NCH is not a power of two.
  generate
    if ((2 ** CW) == NCH) begin : g_full
      assign ch_ok = 1'b1;
    end else begin : g_part
      assign ch_ok = (32'(bus.ch_sel) < NCH);
    end
  endgenerate

  assign sum = {1'b0, acc[bus.ch_sel]} + {1'b0, operand};

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      ovf_q   <= '0;
      operand <= '0;
    end else begin
      if (bus.clear && ch_ok) begin
        acc[bus.ch_sel]   <= '0;
        ovf_q[bus.ch_sel] <= 1'b0;
        operand           <= '0;
      end else begin
        if (bus.add && ch_ok) begin
          acc[bus.ch_sel] <= sum[WIDTH-1:0];
          if (sum[WIDTH]) ovf_q[bus.ch_sel] <= 1'b1;
        end
        if (bus.in_valid)
          operand <= {operand[WIDTH-9:0], bus.in_data};
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      snap       <= '0;
      cnt        <= '0;
      dch        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.dump && ch_ok) begin
            dch    <= bus.ch_sel;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          snap  <= acc[dch];
          cnt   <= CNTW'(NB - 1);
          state <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            tx_data_q  <= snap[WIDTH-1 -: 8];
            tx_start_q <= 1'b1;
            state      <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (cnt != '0) begin
              snap  <= {snap[WIDTH-9:0], 8'h00};
              cnt   <= cnt - CNTW'(1);
              state <= SEND;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: doc/acc_bank_tx.md
ACC_BANK_TX -- requirements
Module: acc_bank_tx

Interface
REQ-001 Parameter WIDTH, default 128, sets accumulator and operand width in bits; a multiple of 8 and at least 16.
REQ-002 Parameter NCH, default 4, sets the number of independent accumulator channels; at least 2.
REQ-003 Derived constants: NB = WIDTH/8 bytes per dump; CW = clog2(NCH) channel-select width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 nRst  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  one-cycle strobe qualifying in_data.
REQ-007 in_data  input  8  operand byte from the host receiver.
REQ-008 ch_sel  input  CW  channel addressed by add, clear and dump.
REQ-009 add  input  1  pulse: accumulate operand into channel ch_sel.
REQ-010 clear  input  1  pulse: zero channel ch_sel and the operand.
REQ-011 dump  input  1  pulse: transmit channel ch_sel byte-serially.
REQ-012 tx_busy  input  1  transmitter busy flag.
REQ-013 tx_start  output  1  one-cycle transmit request.
REQ-014 tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls.
REQ-015 busy  output  1  high while a dump is in progress.
REQ-016 ovf  output  NCH  per-channel sticky carry-out flag.

Function
REQ-017 Operand register, WIDTH bits: each in_valid shifts it left by 8 and loads in_data into bits [7:0], so the last byte received is least significant.
REQ-018 add: acc[ch_sel] <= acc[ch_sel] + operand, modulo 2^WIDTH; registered the cycle after the strobe.
REQ-019 Carry-out from bit WIDTH-1 sets ovf[ch_sel]; ovf is cleared only by clear on that channel or by reset.
REQ-020 add leaves the operand unchanged, so repeated add pulses accumulate the same operand.
REQ-021 clear: acc[ch_sel] <= 0, ovf[ch_sel] <= 0, operand <= 0.
REQ-022 Same-cycle conflicts:
- clear and add together: clear wins and add is discarded.
- in_valid with add: add uses the pre-shift operand.
- in_valid with clear: operand ends at zero.
REQ-023 ch_sel >= NCH: add, clear and dump are all ignored.
REQ-024 Dump FSM states are IDLE, LOAD, SEND, WAIT_HI and WAIT_LO.
REQ-025 IDLE: dump moves to LOAD, and busy goes high on the following edge.
REQ-026 LOAD:
- Copy acc[ch_sel] into a WIDTH-bit snapshot register.
- Capture the channel index.
- Set the byte counter to NB-1.
- Go to SEND.
REQ-027 SEND, when tx_busy is low:
- Drive tx_data = snapshot[WIDTH-1:WIDTH-8], most significant byte first.
- Pulse tx_start for exactly one cycle.
- Go to WAIT_HI.
REQ-028 SEND, when tx_busy is high: stay in SEND and hold tx_start low.
REQ-029 WAIT_HI: wait for tx_busy high, then go to WAIT_LO.
REQ-030 WAIT_LO: wait for tx_busy low, then act on the byte counter:
- If the counter is non-zero: shift the snapshot left by 8, decrement the counter, go to SEND.
- If the counter is zero: go to IDLE and drop busy.
REQ-031 A dump transmits exactly NB bytes, and tx_start pulses exactly NB times.
REQ-032 dump while busy is high is ignored and is not queued.
REQ-033 Snapshot isolation: add, clear and in_valid stay fully functional during a dump, and the transmitted bytes are the value at LOAD.
REQ-034 add on the dumped channel in the same cycle as LOAD: the snapshot holds the pre-add value.
REQ-035 Dump latency: first tx_start is no earlier than 3 cycles after the dump strobe (IDLE, LOAD, SEND).

Reset
REQ-036 nRst low, asynchronously and in any state including mid-dump, forces:
- all acc, operand, snapshot and ovf to 0;
- FSM to IDLE and the byte counter to 0;
- tx_start = 0, tx_data = 0x00, busy = 0.
REQ-037 After nRst rises, the first valid command is accepted on the first rising edge.

Verification
REQ-038 WIDTH=16, NCH=2: in_valid 0x12, then 0x34, then add ch0, then dump ch0 -> tx_data 0x12 then 0x34, two tx_start pulses, busy falls after the second tx_busy falls.
REQ-039 WIDTH=16: operand 0xFFFF, then add ch1 twice -> acc1 = 0xFFFE and ovf[1] = 1; then clear ch1 -> acc1 = 0 and ovf[1] = 0.
REQ-040 Same-cycle add+clear on ch0 after acc0 = 0x0005 -> acc0 = 0 and the operand is 0.
REQ-041 Start a dump of acc0 = 0xAABB, then add 0x0001 to ch0 during WAIT_HI -> bytes 0xAA, 0xBB are sent and acc0 ends at 0xAABC; a second dump issued during the transfer produces no extra tx_start.
REQ-042 Hold tx_busy high for 10 cycles in SEND -> no tx_start until tx_busy falls, and tx_data stays stable through each byte.
REQ-043 Assert nRst in WAIT_LO of a dump -> all outputs are 0 immediately, and a subsequent dump restarts from the first byte.
